// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
// Pointer/occupancy typedefs and fill-status encoding.
package fifo_rd_stream_pkg;

   localparam int BUF_DEPTH = 3;

   typedef logic [1:0] ptr_t;
   typedef logic [1:0] occ_t;

   typedef enum logic [1:0] {
      EMPTY,
      PARTIAL,
      FULL
   } fill_t;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
   endfunction

   function automatic fill_t fill_of(input occ_t o);
      fill_t f;
      if (o == occ_t'(0))
         f = EMPTY;
      else if (o == occ_t'(BUF_DEPTH))
         f = FULL;
      else
         f = PARTIAL;
      return f;
   endfunction

endpackage

// File: rtl/fifo_rd_stream_rd_skid_buf.sv
// 3-entry circular output buffer for fifo_rd_stream.
// Fill status (EMPTY/PARTIAL/FULL) tracks occupancy; valid/data are registered.
module rd_skid_buf
   import fifo_rd_stream_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] dout,
   output occ_t             occ
);

   logic [WIDTH-1:0] mem [BUF_DEPTH];
   ptr_t             head;
   ptr_t             tail;
   occ_t             occ_d;
   fill_t            fill_q;
   fill_t            fill_d;
   logic             pop;

   assign pop = valid && ready;

   // Storage write at tail; data needs no reset.
   always_ff @(posedge clk) begin
      if (push)
         mem[tail] <= din;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (push)
            tail <= ptr_inc(tail);
         if (pop)
            head <= ptr_inc(head);
         occ <= occ_d;
      end
   end

   // Fill-status state register.
   always_ff @(posedge clk) begin
      if (rst)
         fill_q <= EMPTY;
      else
         fill_q <= fill_d;
   end

   // Next occupancy and next fill status.
   always_comb begin
      occ_d = occ;
      unique case ({push, pop})
         2'b10:   occ_d = occ + occ_t'(1);
         2'b01:   occ_d = occ - occ_t'(1);
         default: occ_d = occ;
      endcase
      fill_d = fill_of(occ_d);
   end

   // Outputs come straight from registered state.
   always_comb begin
      valid = (fill_q != EMPTY);
      dout  = mem[head];
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts asyn_fifo read port (1-cycle read latency) into a valid/ready stream.
// Optional accepted-word counter rd_count under `FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             rempty,
   output logic             rinc,
   input  logic [WIDTH-1:0] rdata,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
   ,
   output logic [15:0]      rd_count
`endif
);

   logic       inflight;
   occ_t       occ;
   logic [2:0] level;

   // Read request uses only registered occupancy: no path from m_ready.
   always_comb begin
      level = {1'b0, occ} + {2'b00, inflight};
      rinc  = !rrst && !rempty && (level <= 3'd2);
   end

   // A read issued this cycle returns data next cycle.
   always_ff @(posedge rclk) begin
      if (rrst)
         inflight <= 1'b0;
      else
         inflight <= rinc;
   end

   rd_skid_buf #(
      .WIDTH (WIDTH)
   ) u_buf (
      .clk   (rclk),
      .rst   (rrst),
      .push  (inflight),
      .din   (rdata),
      .ready (m_ready),
      .valid (m_valid),
      .dout  (m_data),
      .occ   (occ)
   );

`ifdef FIFO_RD_STREAM_CNT_EN
   // Count accepted words, wrapping at 16 bits.
   always_ff @(posedge rclk) begin
      if (rrst)
         rd_count <= '0;
      else if (m_valid && m_ready)
         rd_count <= rd_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: vector table plus corner sequences.
// Models the asyn_fifo read side with a queue and 1-cycle read latency.
module tb_fifo_rd_stream;

   logic       rclk;
   logic       rrst;
   logic       rempty;
   logic       rinc;
   logic [7:0] rdata;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
   logic [15:0] rd_count;
`endif

   fifo_rd_stream #(
      .WIDTH (8)
   ) dut (
      .rclk    (rclk),
      .rrst    (rrst),
      .rempty  (rempty),
      .rinc    (rinc),
      .rdata   (rdata),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
      ,
      .rd_count (rd_count)
`endif
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   typedef struct {
      logic       rrst;
      logic       rempty;
      logic       rdy;
      logic       rinc;
      logic       valid;
      logic       dchk;
      logic [7:0] data;
      logic       ochk;
      logic [1:0] occ;
   } vec_t;

   vec_t       tbl [21];
   logic [7:0] q [$];
   logic [7:0] got [$];
   logic [7:0] exp_q [$];
   int         nvec = 0;
   int         nmis = 0;
   int         hs_cnt = 0;
   bit         strict = 1'b1;

   function automatic vec_t mk(bit r, bit e, bit y, bit ri, bit v,
                               bit dc, logic [7:0] d, bit oc,
                               logic [1:0] o);
      vec_t t;
      t.rrst = r; t.rempty = e; t.rdy = y;
      t.rinc = ri; t.valid = v; t.dchk = dc;
      t.data = d; t.ochk = oc; t.occ = o;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      nvec++;
      if (act !== expv) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // One clock: sample handshake/read before the edge, then model FIFO data.
   task automatic step();
      logic       fire;
      logic       hs;
      logic [7:0] hd;
      #2;
      fire = rinc && !rempty;
      hs   = m_valid && m_ready;
      hd   = m_data;
      @(posedge rclk);
      #1;
      if (hs) begin
         got.push_back(hd);
         hs_cnt++;
      end
      if (fire) begin
         if (strict)
            chk("fifo_read_nonempty", 32'(q.size() != 0), 32'd1);
         rdata = (q.size() != 0) ? q.pop_front() : 8'h00;
      end
   endtask

   task automatic drain(input int budget);
      for (int c = 0; c < budget; c++) begin
         rempty  = (q.size() == 0);
         m_ready = 1'b1;
         step();
      end
   endtask

   task automatic cmp_stream(input string name);
      chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got.size(); k++)
         chk($sformatf("%s_word%0d", name, k), 32'(got[k]), 32'(exp_q[k]));
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int viol;
      int cyc;

      tbl[0]  = mk(1, 1, 1, 0, 0, 0, 8'h00, 0, 0);
      tbl[1]  = mk(0, 0, 1, 1, 0, 0, 8'h00, 1, 0);
      tbl[2]  = mk(0, 0, 1, 1, 0, 0, 8'h00, 0, 0);
      tbl[3]  = mk(0, 0, 1, 1, 1, 1, 8'hA1, 1, 1);
      tbl[4]  = mk(0, 1, 1, 0, 1, 1, 8'hA2, 0, 0);
      tbl[5]  = mk(0, 1, 1, 0, 1, 1, 8'hA3, 0, 0);
      tbl[6]  = mk(0, 1, 1, 0, 0, 0, 8'h00, 0, 0);
      tbl[7]  = mk(0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      tbl[8]  = mk(0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      tbl[9]  = mk(0, 0, 0, 1, 1, 1, 8'hB1, 1, 1);
      tbl[10] = mk(0, 0, 0, 0, 1, 1, 8'hB1, 1, 2);
      tbl[11] = mk(0, 0, 0, 0, 1, 1, 8'hB1, 1, 3);
      tbl[12] = mk(0, 0, 1, 0, 1, 1, 8'hB1, 1, 3);
      tbl[13] = mk(0, 0, 0, 1, 1, 1, 8'hB2, 1, 2);
      tbl[14] = mk(0, 0, 0, 0, 1, 1, 8'hB2, 0, 0);
      tbl[15] = mk(0, 0, 0, 0, 1, 1, 8'hB2, 1, 3);
      tbl[16] = mk(0, 0, 1, 0, 1, 1, 8'hB2, 0, 0);
      tbl[17] = mk(0, 0, 1, 1, 1, 1, 8'hB3, 1, 2);
      tbl[18] = mk(0, 1, 1, 0, 1, 1, 8'hB4, 1, 1);
      tbl[19] = mk(0, 1, 1, 0, 1, 1, 8'hB5, 0, 0);
      tbl[20] = mk(0, 1, 1, 0, 0, 0, 8'h00, 1, 0);

      rrst = 1'b1; rempty = 1'b1; m_ready = 1'b0; rdata = 8'h00;
      step();
      step();

      q = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
      got.delete();
      for (int i = 0; i < 21; i++) begin
         rrst    = tbl[i].rrst;
         rempty  = tbl[i].rempty;
         m_ready = tbl[i].rdy;
         #3;
         chk($sformatf("v%0d_rinc", i), 32'(rinc), 32'(tbl[i].rinc));
         chk($sformatf("v%0d_valid", i), 32'(m_valid), 32'(tbl[i].valid));
         if (tbl[i].dchk)
            chk($sformatf("v%0d_data", i), 32'(m_data), 32'(tbl[i].data));
         if (tbl[i].ochk)
            chk($sformatf("v%0d_occ", i), 32'(dut.u_buf.occ),
                32'(tbl[i].occ));
         step();
      end
      exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
      cmp_stream("table_order");

      // rempty toggling, random backpressure
      got.delete();
      q.delete();
      exp_q.delete();
      for (int k = 0; k < 24; k++) begin
         q.push_back(8'(8'h40 + k));
         exp_q.push_back(8'(8'h40 + k));
      end
      viol = 0;
      for (int c = 0; c < 200; c++) begin
         rempty  = (c % 2 == 1) || (q.size() == 0);
         m_ready = 1'($urandom_range(0, 1));
         #2;
         if (rinc && rempty)
            viol++;
         step();
      end
      drain(6);
      chk("rinc_while_empty", 32'(viol), 32'd0);
      cmp_stream("toggle_order");

      // reset with occ=2 and a read in flight
      got.delete();
      q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
      rrst = 1'b0; rempty = 1'b0; m_ready = 1'b0;
      step();
      step();
      step();
      #2;
      chk("pre_rst_occ", 32'(dut.u_buf.occ), 32'd2);
      chk("pre_rst_inflight", 32'(dut.inflight), 32'd1);
      rrst = 1'b1;
      step();
      rrst = 1'b0; rempty = 1'b1; m_ready = 1'b1;
      #3;
      chk("post_rst_valid", 32'(m_valid), 32'd0);
      chk("post_rst_occ", 32'(dut.u_buf.occ), 32'd0);
      q.push_back(8'hE1);
      q.push_back(8'hE2);
      drain(12);
      exp_q = '{8'hD4, 8'hE1, 8'hE2};
      cmp_stream("post_rst_order");

`ifdef FIFO_RD_STREAM_CNT_EN
      rrst = 1'b1; rempty = 1'b1; m_ready = 1'b0;
      step();
      rrst = 1'b0;
      #3;
      chk("cnt_reset", 32'(rd_count), 32'd0);
      strict  = 1'b0;
      hs_cnt  = 0;
      cyc     = 0;
      rempty  = 1'b0;
      m_ready = 1'b1;
      while (hs_cnt < 65535 && cyc < 70000) begin
         step();
         cyc++;
      end
      m_ready = 1'b0;
      rempty  = 1'b1;
      #3;
      chk("cnt_handshakes", 32'(hs_cnt), 32'd65535);
      chk("cnt_throughput", 32'(cyc <= 65540), 32'd1);
      chk("cnt_ffff", 32'(rd_count), 32'hFFFF);
      chk("cnt_valid_before_wrap", 32'(m_valid), 32'd1);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      #3;
      chk("cnt_wrap", 32'(rd_count), 32'd0);
      strict = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
